adder_serial_nb: RTL
====================

# adder_serial_nb

Parametrised, multi-cycle, digit-serial adder/subtractor: the sequential successor of the team's combinational 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-bit full-adder chain. Carry is held in a register between digits. It reports the carry-out and signed overflow, and signals completion with a start/busy/done handshake. It sits in datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 8: operand width in bits; WIDTH ≥ 1.
- DIGIT, 2: bits processed per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise).
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle.
- sub  in  1  0 = A+B, 1 = A−B; captured with start.
- A  in  WIDTH  operand A; captured with start.
- B  in  WIDTH  operand B; captured with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: S/ovf updated this cycle.
- S  out  WIDTH+1  result; S[WIDTH] = carry-out.
- ovf  out  1  two's-complement overflow of S[WIDTH-1:0].

## Operation
- C = WIDTH/DIGIT digit cycles. FSM has two states: IDLE, RUN.
- IDLE & start=1:
  - Latch opA=A and opB = B XOR {WIDTH{sub}}.
  - Set carry=sub and cnt=0; go to RUN.
- RUN, each edge:
  - Add opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the DIGIT-bit sum into the internal result shift register from the MSB end.
  - Shift opA/opB right by DIGIT; update carry; cnt++.
- On the edge where cnt == C−1:
  - Register S = {carry_out, full sum} and ovf = carry into MSB XOR carry out of MSB.
  - Pulse done; return to IDLE.
- Subtraction: S[WIDTH]=1 means no borrow (A ≥ B unsigned).
- S and ovf hold their last value until the next completion. The internal shift register never drives S directly.
- start while busy is ignored; the captured operands are unaffected.
- Back-to-back: start may be asserted during the done cycle (state IDLE) and is accepted on that edge.
- Reset: asynchronous return to IDLE.
  - busy=0, done=0, S=0, ovf=0; internal registers cleared.
  - Reset mid-RUN aborts; no done pulse is generated.

## Timing
- Start accepted at edge 0. busy=1 in the cycles after edges 0..C−1.
- done=1 and the new S/ovf are visible in the cycle after edge C, with busy=0 in that cycle.
- Latency is C cycles start-to-done. Throughput is one operation per C cycles.
- DIGIT=WIDTH gives C=1: done one cycle after start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `adder_serial_pkg`:
  - state enum {IDLE, RUN}.
  - Function computing C and the cnt width $clog2(C) (minimum 1).
- One sub-module, `digit_adder`: combinational DIGIT-bit ripple chain (a, b, cin → s, cout, c_msb_in). It also exports the carry into the top bit, used for ovf.
- Top level contains the FSM, the operand shift registers, the carry register, the counter, and the output registers.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 (C=4) unless noted.
- Reset: assert reset_n=0 mid-run → immediately busy=0, done=0, S=9'h000, ovf=0; no done pulse after release.
- Add with overflow: A=8'h5A, B=8'h3C, sub=0 → done exactly 4 cycles after start, S=9'h096, ovf=1.
- Carry-out: A=8'hFF, B=8'h01, sub=0 → S=9'h100, ovf=0.
- Subtract:
  - A=8'h10, B=8'h20, sub=1 → S=9'h0F0, ovf=0.
  - A=8'h80, B=8'h01, sub=1 → S=9'h17F, ovf=1.
- Handshake:
  - Start with new operands while busy → ignored; the result matches the first operands.
  - Start in the done cycle → accepted, next done 4 cycles later.
  - S holds between operations.
- Parameter sweep: DIGIT ∈ {1,2,4,8} against a reference model on random operands.
  - DIGIT=8 → done 1 cycle after start.
  - Exhaustive for WIDTH=4.

Source files
------------

// File: rtl/adder_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package adder_serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int digit_cycles(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must stay at least one bit wide even when a single digit covers the word.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/adder_serial_nb_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface adder_serial_nb_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   S;
    logic             ovf;

    modport master (
        output start, sub, A, B,
        input  busy, done, S, ovf
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, S, ovf
    );
endinterface

// File: rtl/adder_serial_nb_digit_adder.sv
// DIGIT-bit ripple-carry chain, the only adder hardware in the serial datapath.
// Also exports the carry into the top bit so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/adder_serial_nb.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
// state | meaning
// IDLE  | waiting for start; S/ovf hold the last completed result
// RUN   | one digit per edge; last digit registers S/ovf and pulses done
module adder_serial_nb
    import adder_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic              clock,
    input logic              reset_n,
    adder_serial_nb_if.slave bus
);
    localparam int C     = digit_cycles(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(C);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("adder_serial_nb: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state, state_next;
    logic             load, finish;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT-1:0] sum_d;
    logic             cout_d, c_msb_d;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH:0]   s_q;
    logic             ovf_q, done_q;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a        (op_a[DIGIT-1:0]),
        .b        (op_b[DIGIT-1:0]),
        .cin      (carry),
        .s        (sum_d),
        .cout     (cout_d),
        .c_msb_in (c_msb_d)
    );

    // Earlier digits enter at the top and drift down; on the last edge the
    // current digit plus the register form the whole sum.
    generate
        if (WIDTH > DIGIT) begin : g_acc
            logic [WIDTH-DIGIT-1:0] acc;
            logic [WIDTH-1:0]       acc_cat;

            assign acc_cat  = {sum_d, acc};
            assign sum_full = acc_cat;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    acc <= '0;
                end else if (state == RUN) begin
                    acc <= acc_cat[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_no_acc
            assign sum_full = sum_d;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with sub.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            op_a  <= bus.A;
            op_b  <= bus.B ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            carry <= cout_d;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_q    <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                s_q   <= {cout_d, sum_full};
                ovf_q <= c_msb_d ^ cout_d;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.ovf  = ovf_q;
endmodule
